// File: rtl/minmax_window_tracker_pkg.sv
// Shared types and constants for the min/max window tracker.
package minmax_window_tracker_pkg;

    localparam int SAMPLE_W = 4;

    // Running-extreme seeds: any real sample replaces them.
    localparam logic [SAMPLE_W-1:0] MIN_INIT = {SAMPLE_W{1'b1}};
    localparam logic [SAMPLE_W-1:0] MAX_INIT = {SAMPLE_W{1'b0}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/minmax_window_tracker_if.sv
// Sample-in / result-out handshake bundle for the min/max window tracker.
interface minmax_window_tracker_if;
    import minmax_window_tracker_pkg::*;

    logic                clear;
    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_min;
    logic [SAMPLE_W-1:0] out_max;
    logic [SAMPLE_W-1:0] out_range;
    logic                busy;

    // Producer of samples / consumer of results.
    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_range, busy
    );

    // The tracker itself.
    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_min, out_max, out_range, busy
    );

endinterface

// File: rtl/minmax_window_tracker_cmp.sv
// Unsigned 4-bit magnitude comparator.
module minmax_window_tracker_cmp
    import minmax_window_tracker_pkg::*;
(
    input  logic [SAMPLE_W-1:0] A,
    input  logic [SAMPLE_W-1:0] B,
    output logic                equal,
    output logic                less_than,
    output logic                greater_than
);

    // Pure combinational magnitude compare of A against B.
    always_comb begin
        equal        = (A == B);
        less_than    = (A <  B);
        greater_than = (A >  B);
    end

endmodule

// File: rtl/minmax_window_tracker.sv
// Tracks running min/max over WINDOW accepted samples and presents
// min, max and range on a valid/ready result port until consumed.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  ACCUM | accepting samples, updating running min/max
//  HOLD  | result presented, waiting for out_ready (no samples taken)
module minmax_window_tracker
    import minmax_window_tracker_pkg::*;
#(
    parameter int WINDOW = 8,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    minmax_window_tracker_if.slave bus
);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    count_q;
    logic [SAMPLE_W-1:0] min_r;
    logic [SAMPLE_W-1:0] max_r;
    logic [SAMPLE_W-1:0] out_min_q;
    logic [SAMPLE_W-1:0] out_max_q;
    logic [SAMPLE_W-1:0] out_range_q;

    logic                in_ready;
    logic                out_valid;
    logic                busy;

    logic                accept;
    logic                last;
    logic                lt_min;
    logic                gt_max;
    logic [SAMPLE_W-1:0] cand_min;
    logic [SAMPLE_W-1:0] cand_max;

    assign accept = bus.in_valid && in_ready;
    assign last   = (count_q == CNT_W'(WINDOW - 1));

    minmax_window_tracker_cmp u_cmp_min (
        .A            (bus.in_data),
        .B            (min_r),
        .equal        (),
        .less_than    (lt_min),
        .greater_than ()
    );

    minmax_window_tracker_cmp u_cmp_max (
        .A            (bus.in_data),
        .B            (max_r),
        .equal        (),
        .less_than    (),
        .greater_than (gt_max)
    );

    // Extremes including the sample on the bus; the first sample of a
    // window seeds both regardless of the seed values.
    always_comb begin
        cand_min = min_r;
        cand_max = max_r;
        if (count_q == '0 || lt_min) cand_min = bus.in_data;
        if (count_q == '0 || gt_max) cand_max = bus.in_data;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    // Next-state logic; clear overrides everything, including a handoff.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (accept && last) state_d = HOLD;
                HOLD:    if (bus.out_ready)  state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Moore outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                busy     = (count_q != '0);
            end
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Window accumulation; clear discards a same-cycle sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            min_r   <= MIN_INIT;
            max_r   <= MAX_INIT;
        end else if (bus.clear) begin
            count_q <= '0;
            min_r   <= MIN_INIT;
            max_r   <= MAX_INIT;
        end else if (accept) begin
            if (last) begin
                count_q <= '0;
                min_r   <= MIN_INIT;
                max_r   <= MAX_INIT;
            end else begin
                count_q <= count_q + CNT_W'(1);
                min_r   <= cand_min;
                max_r   <= cand_max;
            end
        end
    end

    // Result registers: loaded on the window's last accept, kept otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_min_q   <= '0;
            out_max_q   <= '0;
            out_range_q <= '0;
        end else if (!bus.clear && accept && last) begin
            out_min_q   <= cand_min;
            out_max_q   <= cand_max;
            out_range_q <= cand_max - cand_min;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_min   = out_min_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_range = out_range_q;

endmodule

// File: tb/tb_minmax_window_tracker.sv
// Directed bench for minmax_window_tracker (WINDOW=8).
module tb_minmax_window_tracker;
    import minmax_window_tracker_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    minmax_window_tracker_if bus ();

    minmax_window_tracker #(.WINDOW(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [3:0] mn,
                              input logic [3:0] mx, input logic [3:0] rg);
        chk({tag, "_valid"}, 8'(bus.out_valid), 8'd1);
        chk({tag, "_min"},   8'(bus.out_min),   8'(mn));
        chk({tag, "_max"},   8'(bus.out_max),   8'(mx));
        chk({tag, "_range"}, 8'(bus.out_range), 8'(rg));
        chk({tag, "_ready"}, 8'(bus.in_ready),  8'd0);
    endtask

    logic [3:0] s1 [8];

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.out_ready = 1'b0;
        s1 = '{4'd5, 4'd3, 4'd9, 4'd3, 4'd12, 4'd0, 4'd7, 4'd12};

        // Reset held three cycles.
        repeat (3) step();
        chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
        chk("rst_busy",      8'(bus.busy),      8'd0);
        rst_n = 1'b1;
        step();
        chk("rel_in_ready",  8'(bus.in_ready),  8'd1);
        chk("rel_out_valid", 8'(bus.out_valid), 8'd0);
        chk("rel_busy",      8'(bus.busy),      8'd0);
        chk("rel_min",       8'(bus.out_min),   8'd0);
        chk("rel_max",       8'(bus.out_max),   8'd0);
        chk("rel_range",     8'(bus.out_range), 8'd0);

        // Back-to-back window 5,3,9,3,12,0,7,12.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = s1[i];
            step();
            if (i == 0) chk("w1_busy_first", 8'(bus.busy), 8'd1);
            if (i == 6) chk("w1_no_early_valid", 8'(bus.out_valid), 8'd0);
        end
        chk_result("w1", 4'd0, 4'd12, 4'd12);
        chk("w1_busy_hold", 8'(bus.busy), 8'd0);

        // Backpressure: samples offered during HOLD must be ignored.
        bus.in_data = 4'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_result("bp", 4'd0, 4'd12, 4'd12);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("hand_out_valid", 8'(bus.out_valid), 8'd0);
        chk("hand_in_ready",  8'(bus.in_ready),  8'd1);
        chk("hand_busy",      8'(bus.busy),      8'd0);
        chk("hand_keep_max",  8'(bus.out_max),   8'd12);

        // Fresh window of eight 6s.
        for (int i = 0; i < 8; i++) send(4'd6);
        chk_result("w2", 4'd6, 4'd6, 4'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("w2_consumed", 8'(bus.out_valid), 8'd0);

        // Clear mid-window, with a sample offered in the same cycle.
        send(4'd1);
        send(4'd15);
        send(4'd2);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd0;
        step();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_busy",      8'(bus.busy),      8'd0);
        chk("clr_out_valid", 8'(bus.out_valid), 8'd0);
        chk("clr_keep_min",  8'(bus.out_min),   8'd6);
        for (int i = 0; i < 8; i++) begin
            send(4'(4 + i));
            if (i == 6) chk("w3_no_early_valid", 8'(bus.out_valid), 8'd0);
        end
        chk_result("w3", 4'd4, 4'd11, 4'd7);

        // Clear in HOLD while the consumer is also accepting.
        bus.clear     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        chk("hclr_out_valid", 8'(bus.out_valid), 8'd0);
        chk("hclr_in_ready",  8'(bus.in_ready),  8'd1);
        chk("hclr_keep_rng",  8'(bus.out_range), 8'd7);
        repeat (3) step();
        chk("hclr_no_second", 8'(bus.out_valid), 8'd0);
        chk("hclr_idle_busy", 8'(bus.busy),      8'd0);

        // Asynchronous reset three samples into a window.
        send(4'd2);
        send(4'd3);
        send(4'd4);
        chk("ar_busy_before", 8'(bus.busy), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy",      8'(bus.busy),      8'd0);
        chk("ar_out_valid", 8'(bus.out_valid), 8'd0);
        chk("ar_min",       8'(bus.out_min),   8'd0);
        chk("ar_max",       8'(bus.out_max),   8'd0);
        chk("ar_range",     8'(bus.out_range), 8'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            send(4'(15 - i));
            if (i == 6) chk("w4_needs_full_window", 8'(bus.out_valid), 8'd0);
        end
        chk_result("w4", 4'd8, 4'd15, 4'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/minmax_window_tracker.md
Name: minmax_window_tracker

Overview:
- Downstream consumer of the 4-bit magnitude comparator.
- Accepts a stream of unsigned 4-bit samples over a valid/ready handshake and tracks the running minimum and maximum across a window of WINDOW samples.
- Uses two comparator instances: sample vs current min, and sample vs current max.
- At window end, presents min, max and range (max-min) on a valid/ready output port, and holds them until consumed.

Parameters:
- WINDOW, 8, number of accepted samples per result; legal range 1..15.
- CNT_W, 4, sample-counter width; must satisfy 2**CNT_W > WINDOW.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort of the current window.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample.
- in_data  input  4  unsigned sample.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_min  output  4  window minimum.
- out_max  output  4  window maximum.
- out_range  output  4  out_max - out_min.
- busy  output  1  at least one sample accepted in the current window, result not yet emitted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACCUM, count=0, min_r=4'hF, max_r=4'h0.
  - out_valid=0, out_min=0, out_max=0, out_range=0, busy=0.
  - in_ready=1 from the first cycle after release.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept rule: a sample is taken only on a rising edge with in_valid&&in_ready. in_data is don't-care otherwise.
- ACCUM, sample accepted:
  - count==0: min_r and max_r both load in_data.
  - Otherwise: min_r<=in_data iff comparator(A=in_data,B=min_r).less_than; max_r<=in_data iff comparator(A=in_data,B=max_r).greater_than.
  - Equal: no update.
  - Comparison is unsigned 4-bit.
  - count<=count+1.
- Window end: on the accept with count==WINDOW-1:
  - Next cycle: state=HOLD, out_valid=1.
  - out_min/out_max/out_range are registered including the last sample.
  - count<=0.
  - Latency is 1 cycle from last accept to out_valid.
- out_range = out_max - out_min, 4-bit. Never negative, because max>=min is invariant.
- HOLD:
  - Outputs stable while out_valid && !out_ready.
  - On out_valid&&out_ready: next cycle state=ACCUM, out_valid=0, in_ready=1. out_min/out_max/out_range keep their last values.
  - No sample is accepted in the handoff cycle, since in_ready=0 in HOLD.
- busy = (state==ACCUM && count!=0).
- clear (highest priority, synchronous):
  - Next cycle: state=ACCUM, count=0, min_r=F, max_r=0, out_valid=0.
  - Any sample accepted in the same cycle is discarded.
  - A pending HOLD result is dropped even if out_ready=1 that cycle; the consumer must treat it as not delivered.
  - out_min/out_max/out_range retain their values.
- WINDOW=1: every accepted sample produces a result with min=max=sample, range=0. Throughput is 1 result per 2 cycles.
- Reset mid-window or in HOLD: all state is discarded immediately, with the reset values above.
- in_valid held high continuously in ACCUM: one sample per cycle; no bubbles until window end.

Decomposition:
- Shared package: SAMPLE_W=4 and a state enum {ACCUM, HOLD}.
- Sub-module: the existing comparator (ports A, B, equal, less_than, greater_than), instantiated twice (u_cmp_min, u_cmp_max).
- The equal output is unused and left unconnected.
- No other sub-modules.

Test Plan:
- Reset check: rst_n low 3 cycles then high -> out_valid=0, in_ready=1, busy=0, all data outputs 0.
- WINDOW=8, back-to-back stream 5,3,9,3,12,0,7,12 -> one cycle after the 8th accept: out_valid=1, out_min=0, out_max=12, out_range=12, in_ready=0.
- Backpressure: same stream, out_ready low 5 cycles after out_valid -> outputs stable 0/12/12, in_valid samples ignored. Raise out_ready -> out_valid=0 next cycle, then the next window starts fresh (stream 8×4'h6 -> min=6, max=6, range=0).
- Clear mid-window: accept 1,15,2, assert clear with in_valid and data 0 -> count resets, sample 0 discarded. The next 8 samples 4..11 -> min=4, max=11, range=7.
- Clear in HOLD with out_ready=1 the same cycle -> out_valid=0 next cycle, in_ready=1, no second result emitted.
- Async reset asserted mid-cycle during a window (3 samples in) -> outputs go to reset values without waiting for clk. After release, a full window of 8 samples is required for a result.
